subtrator_serial: RTL and testbench

//   Bit-serial N-bit unsigned subtractor (diff = a - b), LSB first, one bit per clock.

---
 rtl/subtrator_serial.sv | 137 +++++++++++++
 tb/tb_subtrator_serial.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/subtrator_serial.sv
// -----------------------------------------------------------------------------
// subtrator_serial
//   Bit-serial N-bit unsigned subtractor, diff = a - b (mod 2^N), LSB first,
//   one bit per clock. The per-bit cell is a full subtractor built from two
//   cascaded half-subtractor stages. A borrow flip-flop carries the borrow
//   between bits.
//
//   Sequence per operation: IDLE -> SHIFT (N cycles) -> DONE (1 cycle) -> IDLE.
//   When start is held high, operations run back to back, one every N+2 cycles.
//
// Ports
//   clk     in   1  rising-edge clock
//   rst     in   1  asynchronous, active-high reset
//   start   in   1  request, sampled only in IDLE
//   a       in   N  minuend, captured on the accepted start edge
//   b       in   N  subtrahend, captured on the accepted start edge
//   busy    out  1  high in SHIFT and DONE
//   done    out  1  one-cycle pulse while diff/borrow are valid
//   diff    out  N  a - b mod 2^N; holds until the next accepted start
//   borrow  out  1  borrow out of the MSB (a < b); holds until next result
// -----------------------------------------------------------------------------
module subtrator_serial #(
  parameter int N = 8  // legal range 2..64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] diff,
  output logic         borrow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [6:0] LAST_CNT = 7'(N - 1);

  state_t       state, state_nxt;
  logic [N-1:0] sa, sb;   // operand shift registers, consumed from bit 0
  logic         bff;      // borrow carried between bit positions
  logic [6:0]   cnt;      // bit index currently being processed

  // Full-subtractor cell built from two half-subtractor stages.
  logic x, y, bin;
  logic d1, b1;           // stage 1: x - y
  logic d, b2;            // stage 2: d1 - bin
  logic bout;

  assign x    = sa[0];
  assign y    = sb[0];
  assign bin  = bff;
  assign d1   = x ^ y;
  assign b1   = ~x & y;
  assign d    = d1 ^ bin;
  assign b2   = ~d1 & bin;
  assign bout = b1 | b2;

  wire last_bit = (cnt == LAST_CNT);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: state elements use non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment at the top keeps every path driven, so no
  // latch is inferred when a case branch leaves the state unchanged.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from state only, so there is no combinational path
  // from any input.
  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa     <= '0;
      sb     <= '0;
      bff    <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      borrow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa   <= a;
            sb   <= b;
            bff  <= 1'b0;
            cnt  <= '0;
            diff <= '0;
          end
        end
        SHIFT: begin
          bff  <= bout;
          // Result bits enter at the MSB. After N shifts, the first (LSB)
          // result bit has arrived at bit 0.
          diff <= {d, diff[N-1:1]};
          sa   <= sa >> 1;
          sb   <= sb >> 1;
          if (last_bit) begin
            cnt    <= '0;
            borrow <= bout;
          end else begin
            cnt <= cnt + 7'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_subtrator_serial.sv
// -----------------------------------------------------------------------------
// tb_subtrator_serial
//   Self-checking bench for subtrator_serial. It runs directed N=8 vectors
//   from a table, then hand-written sequences for the two multi-cycle corner
//   cases: start pulsed while busy, and reset asserted mid-operation. A second
//   instance with N=4 runs all 256 operand pairs with start held high.
// -----------------------------------------------------------------------------
module tb_subtrator_serial;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a, b;
  logic       busy, done;
  logic [7:0] diff;
  logic       borrow;

  logic       start4;
  logic [3:0] a4, b4;
  logic       busy4, done4;
  logic [3:0] diff4;
  logic       borrow4;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  subtrator_serial #(.N(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
  );

  subtrator_serial #(.N(4)) dut4 (
    .clk    (clk),
    .rst    (rst),
    .start  (start4),
    .a      (a4),
    .b      (b4),
    .busy   (busy4),
    .done   (done4),
    .diff   (diff4),
    .borrow (borrow4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;
    logic       bo;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Starts one N=8 operation from IDLE and returns the result and the latency.
  // Latency is the number of edges after the accept edge until done is seen.
  // If pulse_at > 0, start is pulsed with new operands in that SHIFT cycle.
  // The task returns one cycle after done, with the DUT back in IDLE.
  task automatic run8(input logic [7:0] ta, input logic [7:0] tb_v, input int pulse_at,
                      output logic [7:0] d, output logic bo, output int lat);
    int bad_busy;
    bad_busy = 0;
    a = ta;
    b = tb_v;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      start = 1'b0;
      if (done) break;
      if (!busy) bad_busy++;
      if (lat == pulse_at) begin
        start = 1'b1;
        a = 8'hFF;
        b = 8'h01;
      end
    end
    d  = diff;
    bo = borrow;
    check("busy_during_shift", 64'(bad_busy), 64'd0);
    check("busy_in_done", 64'(busy), 64'd1);
    @(posedge clk);
    #1;
    check("done_one_cycle", 64'(done), 64'd0);
    check("idle_after_done", 64'(busy), 64'd0);
  endtask

  initial begin
    logic [7:0] rd;
    logic       rb;
    int         lat;
    int         last_cyc;
    logic       got;
    logic [3:0] ea, eb;

    vecs[0] = '{a: 8'd5,  b: 8'd3,  d: 8'd2,  bo: 1'b0};
    vecs[1] = '{a: 8'd3,  b: 8'd5,  d: 8'hFE, bo: 1'b1};
    vecs[2] = '{a: 8'h00, b: 8'hFF, d: 8'h01, bo: 1'b1};
    vecs[3] = '{a: 8'hA5, b: 8'hA5, d: 8'h00, bo: 1'b0};
    vecs[4] = '{a: 8'h80, b: 8'h01, d: 8'h7F, bo: 1'b0};
    vecs[5] = '{a: 8'hFF, b: 8'h00, d: 8'hFF, bo: 1'b0};
    vecs[6] = '{a: 8'h01, b: 8'h02, d: 8'hFF, bo: 1'b1};

    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    start4 = 1'b0;
    a4 = '0;
    b4 = '0;

    // Reset state
    #12;
    check("rst_busy",   64'(busy),   64'd0);
    check("rst_done",   64'(done),   64'd0);
    check("rst_diff",   64'(diff),   64'd0);
    check("rst_borrow", 64'(borrow), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed vectors
    foreach (vecs[i]) begin
      run8(vecs[i].a, vecs[i].b, -1, rd, rb, lat);
      check($sformatf("vec%0d_diff", i),    64'(rd),  64'(vecs[i].d));
      check($sformatf("vec%0d_borrow", i),  64'(rb),  64'(vecs[i].bo));
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'd8);
    end

    // The result holds while idle.
    repeat (3) @(posedge clk);
    #1;
    check("hold_diff",   64'(diff),   64'hFF);
    check("hold_borrow", 64'(borrow), 64'd1);

    // A start pulse with new operands in the 3rd SHIFT cycle is ignored.
    run8(8'd5, 8'd3, 2, rd, rb, lat);
    check("busy_start_diff",    64'(rd),  64'd2);
    check("busy_start_borrow",  64'(rb),  64'd0);
    check("busy_start_latency", 64'(lat), 64'd8);
    repeat (2) @(posedge clk);
    #1;
    check("busy_start_no_rerun", 64'(busy), 64'd0);

    // Reset in the 4th SHIFT cycle. The preceding op leaves borrow=1.
    run8(8'd3, 8'd5, -1, rd, rb, lat);
    check("pre_rst_borrow", 64'(rb), 64'd1);
    a = 8'h77;
    b = 8'h11;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy",   64'(busy),   64'd0);
    check("mid_rst_done",   64'(done),   64'd0);
    check("mid_rst_diff",   64'(diff),   64'd0);
    check("mid_rst_borrow", 64'(borrow), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    run8(8'h10, 8'h01, -1, rd, rb, lat);
    check("post_rst_diff",    64'(rd),  64'h0F);
    check("post_rst_borrow",  64'(rb),  64'd0);
    check("post_rst_latency", 64'(lat), 64'd8);

    // N=4 exhaustive run with start held high (pair k: a=k[7:4], b=k[3:0]).
    a4 = 4'd0;
    b4 = 4'd0;
    start4 = 1'b1;
    last_cyc = 0;
    for (int k = 0; k < 256; k++) begin
      got = 1'b0;
      for (int t = 0; t < 20; t++) begin
        @(posedge clk);
        #1;
        if (done4) begin
          got = 1'b1;
          break;
        end
      end
      if (!got) begin
        check($sformatf("n4_done_seen_%0d", k), 64'(got), 64'd1);
        break;
      end
      ea = 4'(k >> 4);
      eb = 4'(k & 15);
      check($sformatf("n4_diff_%0d", k),   64'(diff4),   64'(4'(ea - eb)));
      check($sformatf("n4_borrow_%0d", k), 64'(borrow4), 64'(ea < eb));
      if (k > 0) check($sformatf("n4_period_%0d", k), 64'(cyc - last_cyc), 64'd6);
      last_cyc = cyc;
      // The next pair is captured at the accept edge two edges from now.
      a4 = 4'((k + 1) >> 4);
      b4 = 4'((k + 1) & 15);
    end
    start4 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
